// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and line-word helper for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W          = 10;
    localparam int NUM_BLOCKS      = 8;
    localparam int WORDS_PER_BLOCK = 4;

    localparam int WORD_W     = 32;
    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam int OFF_W      = $clog2(WORDS_PER_BLOCK);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W - 2;
    localparam int LINE_W     = WORD_W * WORDS_PER_BLOCK;
    localparam int BLK_ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        FILL    = 2'd2
    } state_e;

    // Word k sits at bits [32k+31:32k] of the little-endian line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one write port, one combinational read port; only valid bits reset.
module icache_line_array
    import icache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_data_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, blocking 16-byte refill on miss.
module icache_dm
    import icache_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       PC,
    input  logic              READ,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [5:0]        MEM_ADDRESS,
    input  logic [LINE_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    state_e                state_q, state_d;
    logic                  first_q, first_d;
    logic [BLK_ADDR_W-1:0] maddr_q, maddr_d;
    logic [LINE_W-1:0]     fill_q,  fill_d;

    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  pc_idx;
    logic [OFF_W-1:0]  pc_off;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic              hit;
    logic              wr_en;
    logic              unused_pc;

    assign pc_tag    = PC[ADDR_W-1 -: TAG_W];
    assign pc_idx    = PC[OFF_W+2 +: IDX_W];
    assign pc_off    = PC[2 +: OFF_W];
    assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

    icache_line_array u_lines (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .wr_en_i    (wr_en),
        .wr_idx_i   (maddr_q[IDX_W-1:0]),
        .wr_tag_i   (maddr_q[BLK_ADDR_W-1 -: TAG_W]),
        .wr_data_i  (fill_q),
        .rd_idx_i   (pc_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data)
    );

    assign hit = READ & rd_valid & (rd_tag == pc_tag);

    // Forced to zero off a hit so unfilled (never-reset) data never leaks X onto the port.
    assign INSTRUCTION = hit ? line_word(rd_data, pc_off) : '0;
    assign MEM_ADDRESS = maddr_q;

    always_comb begin
        state_d  = state_q;
        first_d  = 1'b0;
        maddr_d  = maddr_q;
        fill_d   = fill_q;
        BUSYWAIT = 1'b0;
        MEM_READ = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                BUSYWAIT = READ & ~hit;
                if (READ && !hit) begin
                    state_d = MEM_REQ;
                    first_d = 1'b1;
                    maddr_d = {pc_tag, pc_idx};
                end
            end
            MEM_REQ: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                // The memory needs one edge to raise its busy flag, so the first cycle is ignored.
                if (!first_q && !MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = FILL;
                end
            end
            FILL: begin
                BUSYWAIT = 1'b1;
                wr_en    = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            maddr_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            maddr_q <= maddr_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a fixed-latency block memory model.
module tb_icache_dm;

    localparam int MEM_LAT = 5;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic [31:0]  PC = '0;
    logic         READ = 1'b0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    logic [31:0] img [0:255];
    int          n_checks = 0;
    int          n_errors = 0;
    int          mem_cnt  = 0;
    logic        mem_busy = 1'b0;

    icache_dm dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .PC           (PC),
        .READ         (READ),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: busy from the edge after MEM_READ is seen until MEM_LAT request cycles have elapsed.
    assign MEM_BUSYWAIT = mem_busy;
    assign MEM_READDATA = {img[{MEM_ADDRESS, 2'd3}], img[{MEM_ADDRESS, 2'd2}],
                           img[{MEM_ADDRESS, 2'd1}], img[{MEM_ADDRESS, 2'd0}]};

    always @(posedge CLK) begin
        if (!MEM_READ) begin
            mem_cnt  <= 0;
            mem_busy <= 1'b0;
        end else begin
            mem_cnt  <= mem_cnt + 1;
            mem_busy <= (mem_cnt + 1 < MEM_LAT - 1);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        READ    = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Presents pc, waits out any stall, checks the word; returns stall cycles and request cycles.
    task automatic fetch(input logic [31:0] pc, output int cyc, output int nreq,
                         output logic first_busy);
        logic [5:0] blk;
        blk  = pc[9:4];
        PC   = pc;
        READ = 1'b1;
        cyc  = 0;
        nreq = 0;
        @(negedge CLK);
        first_busy = BUSYWAIT;
        while (BUSYWAIT && cyc < 40) begin
            if (MEM_READ) begin
                nreq++;
                check_eq("mem_addr", {26'd0, MEM_ADDRESS}, {26'd0, blk});
            end
            cyc++;
            @(negedge CLK);
        end
        check_eq("busy_bound", {31'd0, BUSYWAIT}, 32'd0);
        check_eq("instr", INSTRUCTION, img[pc[9:2]]);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int   cyc, nreq, misses;
        logic fb;

        for (int i = 0; i < 256; i++) img[i] = 32'hC0DE_0000 | i;
        img[0] = 32'h0004_0005;
        img[1] = 32'h0002_0009;
        img[2] = 32'h0206_0402;
        img[3] = 32'h0000_0000;

        // Reset state
        @(negedge CLK);
        check_eq("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        check_eq("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        check_eq("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Cold miss
        fetch(32'h0, cyc, nreq, fb);
        check_eq("cold_busy_now", {31'd0, fb}, 32'd1);
        check_eq("cold_cycles", cyc, 32'd7);
        check_eq("cold_reqs", nreq, MEM_LAT);

        // Spatial hits
        for (int a = 4; a <= 12; a += 4) begin
            fetch(a, cyc, nreq, fb);
            check_eq("hit_cycles", cyc, 32'd0);
            check_eq("hit_reqs", nreq, 32'd0);
        end

        // Conflict misses on index 0
        fetch(32'h080, cyc, nreq, fb);
        check_eq("conf_a_cycles", cyc, 32'd7);
        fetch(32'h000, cyc, nreq, fb);
        check_eq("conf_b_cycles", cyc, 32'd7);

        // Sequential program from a cold cache
        do_reset();
        misses = 0;
        for (int a = 0; a <= 32'h0FC; a += 4) begin
            fetch(a, cyc, nreq, fb);
            if (cyc != 0) misses++;
        end
        check_eq("seq_misses", misses, 32'd16);

        // Reset during the third request cycle abandons the miss
        fetch(32'h000, cyc, nreq, fb);
        fetch(32'h000, cyc, nreq, fb);
        check_eq("prefill_hit", cyc, 32'd0);
        PC   = 32'h040;
        READ = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        check_eq("mid_mem_read", {31'd0, MEM_READ}, 32'd1);
        check_eq("mid_mem_addr", {26'd0, MEM_ADDRESS}, 32'd4);
        RESET_N = 1'b0;
        #1;
        check_eq("abort_mem_read", {31'd0, MEM_READ}, 32'd0);
        check_eq("abort_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        check_eq("abort_busy", {31'd0, BUSYWAIT}, 32'd1);
        READ = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        fetch(32'h000, cyc, nreq, fb);
        check_eq("post_rst_miss", cyc, 32'd7);

        // READ low on an uncached address never stalls or requests
        PC   = 32'h3FC;
        READ = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check_eq("idle_busy", {31'd0, BUSYWAIT}, 32'd0);
            check_eq("idle_mem_read", {31'd0, MEM_READ}, 32'd0);
        end
        @(posedge CLK);
        #1;
        fetch(32'h3FC, cyc, nreq, fb);
        check_eq("top_block_miss", cyc, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
